// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst scheduler for the FIFO read port. A word reaches dout one cycle after fifo_rinc; pops stall on empty, dout backpressure or req drop.
// Optional FIFO_RD_ARB_TIMEOUT_EN adds an empty-stall watchdog that aborts the burst after TIMEOUT cycles.
module fifo_rd_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ID_W      = 2,
   parameter int DATA_SIZE = 8,
   parameter int LEN_W     = 4
`ifdef FIFO_RD_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT   = 16
`endif
) (
   input  logic                     rclk,
   input  logic                     rrst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*LEN_W-1:0] burst_len,
   input  logic                     fifo_rempty,
   input  logic [DATA_SIZE-1:0]     fifo_rdata,
   output logic                     fifo_rinc,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [DATA_SIZE-1:0]     dout,
   output logic                     dout_valid,
   output logic [ID_W-1:0]          dout_id,
   input  logic                     dout_ready,
   output logic                     burst_done,
   output logic                     timeout
);

   typedef enum logic {IDLE, BURST} state_t;

   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   state_t               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [ID_W-1:0]      gid_q, gid_d;
   logic [LEN_W:0]       cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic [DATA_SIZE-1:0] dout_q;
   logic                 dout_vld_q;
   logic [ID_W-1:0]      dout_id_q;

   logic                 sel_vld;
   logic [ID_W-1:0]      sel_id;
   logic [ID_W-1:0]      cand;
   logic [LEN_W-1:0]     len_sel;
   logic                 tmo_hit;

`ifdef FIFO_RD_ARB_TIMEOUT_EN
   localparam int STW = $clog2(TIMEOUT + 1);
   logic [STW-1:0]       stall_q, stall_d;
   logic                 tmo_q, tmo_d;
`endif

   // Scan downward so the nearest set request after the pointer wins last.
   always_comb begin
      sel_vld = 1'b0;
      sel_id  = '0;
      cand    = '0;
      len_sel = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         if (req[cand]) begin
            sel_vld = 1'b1;
            sel_id  = cand;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_id == ID_W'(i)) len_sel = burst_len[i*LEN_W +: LEN_W];
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gid_d     = gid_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      fifo_rinc = 1'b0;
      tmo_hit   = 1'b0;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
      stall_d   = stall_q;
      tmo_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (sel_vld) begin
               state_d = BURST;
               gid_d   = sel_id;
               cnt_d   = (len_sel == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_sel};
`ifdef FIFO_RD_ARB_TIMEOUT_EN
               stall_d = '0;
`endif
            end
         end
         BURST: begin
            fifo_rinc = ~fifo_rempty & (~dout_vld_q | dout_ready) & req[gid_q];
`ifdef FIFO_RD_ARB_TIMEOUT_EN
            tmo_hit = fifo_rempty && (stall_q == STW'(TIMEOUT - 1));
            stall_d = (fifo_rempty && !fifo_rinc) ? stall_q + 1'b1 : '0;
            tmo_d   = tmo_hit;
`endif
            if (fifo_rinc) cnt_d = cnt_q - 1'b1;
            if (!req[gid_q] || tmo_hit || (fifo_rinc && cnt_q == (LEN_W+1)'(1))) begin
               state_d = IDLE;
               done_d  = 1'b1;
               ptr_d   = gid_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q <= IDLE;
         ptr_q   <= LAST_ID;
         gid_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
         stall_q <= '0;
         tmo_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
         stall_q <= stall_d;
         tmo_q   <= tmo_d;
`endif
      end
   end

   // A load and an accept in the same cycle keep the stage full.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         dout_id_q  <= '0;
      end else if (fifo_rinc) begin
         dout_q     <= fifo_rdata;
         dout_vld_q <= 1'b1;
         dout_id_q  <= gid_q;
      end else if (dout_ready) begin
         dout_vld_q <= 1'b0;
      end
   end

   always_comb begin
      gnt = '0;
      if (state_q == BURST) gnt[gid_q] = 1'b1;
   end

   assign dout       = dout_q;
   assign dout_valid = dout_vld_q;
   assign dout_id    = dout_id_q;
   assign burst_done = done_q;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
   assign timeout    = tmo_q;
`else
   assign timeout    = 1'b0;
`endif

endmodule
